// File: rtl/m_ext_pkg.sv
// Shared RV32M definitions: opcodes, FSM states, and opcode classification helpers.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package m_ext_pkg;

  localparam int M_XLEN = 32;

  localparam logic [4:0] OP_MUL    = 5'b01011;
  localparam logic [4:0] OP_MULH   = 5'b01100;
  localparam logic [4:0] OP_MULHSU = 5'b01101;
  localparam logic [4:0] OP_MULHU  = 5'b01110;
  localparam logic [4:0] OP_DIV    = 5'b01111;
  localparam logic [4:0] OP_DIVU   = 5'b10000;
  localparam logic [4:0] OP_REM    = 5'b10001;
  localparam logic [4:0] OP_REMU   = 5'b10010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // True for any of the eight M-extension operations.
  function automatic logic is_m_op(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  // True for the divide/remainder half of the M-extension.
  function automatic logic is_div_op(input logic [4:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Unsigned iterative datapath: radix-2 shift-add multiply or restoring divide, one bit per step.
// Latency: W steps after load; the *_nxt outputs show the value after the current step.
// Backpressure: none; the caller sequences load/step.
module muldiv_core #(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic [W-1:0]     a_mag,
  input  logic [W-1:0]     b_mag,
  output logic [2*W-1:0]   prod_nxt,
  output logic [W-1:0]     quot_nxt,
  output logic [W-1:0]     rem_nxt
);

  // hi: upper product half / partial remainder; lo: multiplier bits / dividend-then-quotient.
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] lo_q, lo_d;
  logic [W-1:0] opb_q, opb_d;
  logic         mode_q, mode_d;
  logic [W:0]   sum;
  logic [W:0]   r_sh;
  logic [W:0]   diff;

  // Load operands or perform one shift-add / restore-subtract step.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opb_d  = opb_q;
    mode_d = mode_q;
    sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    r_sh   = {hi_q, lo_q[W-1]};
    diff   = r_sh - {1'b0, opb_q};
    if (load) begin
      hi_d   = '0;
      mode_d = div_mode;
      if (div_mode) begin
        lo_d  = a_mag;
        opb_d = b_mag;
      end else begin
        lo_d  = b_mag;
        opb_d = a_mag;
      end
    end else if (step) begin
      if (mode_q) begin
        // A shifted remainder that overflows W bits always exceeds the divisor,
        // so the restore path never needs the top bit.
        if (!diff[W]) begin
          hi_d = diff[W-1:0];
          lo_d = {lo_q[W-2:0], 1'b1};
        end else begin
          hi_d = r_sh[W-1:0];
          lo_d = {lo_q[W-2:0], 1'b0};
        end
      end else begin
        hi_d = sum[W:1];
        lo_d = {sum[0], lo_q[W-1:1]};
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opb_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opb_q  <= opb_d;
      mode_q <= mode_d;
    end
  end

  assign prod_nxt = {hi_d, lo_d};
  assign quot_nxt = lo_d;
  assign rem_nxt  = hi_d;

endmodule

// File: rtl/iter_muldiv_unit.sv
// RV32M iterative multiply/divide for Execute: sign handling, special cases, FSM, result register.
// Latency: 33 cycles from accept for normal ops, 1 cycle for divide-by-zero / signed overflow.
// Backpressure: mul_use stalls the pipeline from the accept cycle until the result cycle.
module iter_muldiv_unit
  import m_ext_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            startE,
  input  logic [4:0]      alu_opE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            flushE,
  output logic            mul_use,
  output logic            flagM,
  output logic            flagD,
  output logic [XLEN-1:0] result_m
);

  localparam int            CW       = $clog2(ITER);
  localparam logic [CW-1:0] CNT_LOAD = CW'(ITER - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              flag_m_q, flag_m_d;
  logic              flag_d_q, flag_d_d;

  logic              a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              is_rem_in, div_zero, div_ovf;
  logic              mul_use_c, core_load, core_step;
  logic [2*XLEN-1:0] prod_nxt, prod_fix;
  logic [XLEN-1:0]   quot_nxt, rem_nxt, final_res;

  // Classify the incoming operands: signedness, magnitudes and divide special cases.
  always_comb begin
    a_sgn     = alu_opE inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_sgn     = alu_opE inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    a_neg     = a_sgn & SrcAE[XLEN-1];
    b_neg     = b_sgn & SrcBE[XLEN-1];
    a_mag     = a_neg ? -SrcAE : SrcAE;
    b_mag     = b_neg ? -SrcBE : SrcBE;
    is_rem_in = (alu_opE == OP_REM) || (alu_opE == OP_REMU);
    div_zero  = (SrcBE == '0);
    div_ovf   = ((alu_opE == OP_DIV) || (alu_opE == OP_REM)) &&
                (SrcAE == INT_MIN) && (SrcBE == '1);
  end

  // Apply the latched sign to the post-step core value and pick the architectural result.
  always_comb begin
    prod_fix = neg_q ? -prod_nxt : prod_nxt;
    case (op_q)
      OP_MUL:                        final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               final_res = neg_q ? -quot_nxt : quot_nxt;
      default:                       final_res = neg_q ? -rem_nxt : rem_nxt;
    endcase
  end

  // Next-state, stall and result-register logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    result_d  = '0;
    flag_m_d  = 1'b0;
    flag_d_d  = 1'b0;
    mul_use_c = 1'b0;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        mul_use_c = startE & is_m_op(alu_opE) & ~flushE;
        if (mul_use_c) begin
          op_d  = alu_opE;
          cnt_d = CNT_LOAD;
          // A remainder takes the dividend's sign; products and quotients take A^B.
          neg_d = is_rem_in ? a_neg : (a_neg ^ b_neg);
          if (is_div_op(alu_opE) && div_zero) begin
            state_d  = S_DONE;
            flag_d_d = 1'b1;
            result_d = is_rem_in ? SrcAE : '1;
          end else if (div_ovf) begin
            state_d  = S_DONE;
            flag_d_d = 1'b1;
            result_d = is_rem_in ? '0 : INT_MIN;
          end else begin
            core_load = 1'b1;
            state_d   = is_div_op(alu_opE) ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL, S_DIV: begin
        mul_use_c = 1'b1;
        core_step = 1'b1;
        if (flushE) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = final_res;
          flag_m_d = (state_q == S_MUL);
          flag_d_d = (state_q == S_DIV);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      flag_m_q <= 1'b0;
      flag_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      flag_m_q <= flag_m_d;
      flag_d_q <= flag_d_d;
    end
  end

  muldiv_core #(.W(XLEN)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .step     (core_step),
    .div_mode (is_div_op(alu_opE)),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .prod_nxt (prod_nxt),
    .quot_nxt (quot_nxt),
    .rem_nxt  (rem_nxt)
  );

  // A flush in the result cycle kills the pulse; reset forces the stall low immediately.
  assign mul_use  = mul_use_c & ~rst;
  assign flagM    = flag_m_q & ~flushE;
  assign flagD    = flag_d_q & ~flushE;
  assign result_m = result_q & {XLEN{~flushE}};

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Bench for iter_muldiv_unit: directed cases plus random ops against an arithmetic reference model.
// Latency: checks 33-cycle normal and 1-cycle special-case completion.
// Backpressure: checks mul_use across every busy cycle.
module tb_iter_muldiv_unit;

  localparam logic [4:0] OP_MUL    = 5'b01011;
  localparam logic [4:0] OP_MULH   = 5'b01100;
  localparam logic [4:0] OP_MULHSU = 5'b01101;
  localparam logic [4:0] OP_MULHU  = 5'b01110;
  localparam logic [4:0] OP_DIV    = 5'b01111;
  localparam logic [4:0] OP_DIVU   = 5'b10000;
  localparam logic [4:0] OP_REM    = 5'b10001;
  localparam logic [4:0] OP_REMU   = 5'b10010;

  logic        clk = 1'b0;
  logic        rst;
  logic        startE;
  logic [4:0]  alu_opE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        flushE;
  logic        mul_use;
  logic        flagM;
  logic        flagD;
  logic [31:0] result_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iter_muldiv_unit dut (
    .clk      (clk),
    .rst      (rst),
    .startE   (startE),
    .alu_opE  (alu_opE),
    .SrcAE    (SrcAE),
    .SrcBE    (SrcBE),
    .flushE   (flushE),
    .mul_use  (mul_use),
    .flagM    (flagM),
    .flagD    (flagD),
    .result_m (result_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural RV32M result computed with wide integer arithmetic.
  function automatic logic [31:0] ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ub = longint'({32'b0, b});
    longint      p;
    logic [63:0] up;
    logic [31:0] r;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (op)
      OP_MUL:    begin p = sa * sb; r = p[31:0]; end
      OP_MULH:   begin p = sa * sb; r = p[63:32]; end
      OP_MULHSU: begin p = sa * ub; r = p[63:32]; end
      OP_MULHU:  begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
      OP_DIV: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (ovf) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      OP_REM: begin
        if (b == 0) r = a;
        else if (ovf) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      OP_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < OP_DIV) return 1'b0;
    if (b == 0) return 1'b1;
    return ((op == OP_DIV) || (op == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  // Issue one op, optionally re-present startE with another op at cycle T+poke,
  // and check stall length, completion cycle, flag type, result and post-result idle.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int poke);
    int          busy;
    int          n;
    bit          seen;
    logic [31:0] got;
    logic        gm, gd;
    logic [31:0] exp_res;
    int          exp_lat;
    bit          exp_div;
    exp_res = ref_op(op, a, b);
    exp_lat = is_special(op, a, b) ? 1 : 33;
    exp_div = (op >= OP_DIV);
    @(negedge clk);
    startE = 1'b1; alu_opE = op; SrcAE = a; SrcBE = b;
    #1;
    busy = mul_use ? 1 : 0;
    seen = 1'b0; n = 0; got = '0; gm = 1'b0; gd = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      startE = (n == poke);
      if (startE) begin
        alu_opE = OP_MULHU; SrcAE = 32'd3; SrcBE = 32'd3;
      end
      #1;
      if (flagM || flagD) begin
        seen = 1'b1; got = result_m; gm = flagM; gd = flagD;
        chk({tag, " mul_use@done"}, 32'(mul_use), 32'd0);
      end else if (mul_use) begin
        busy++;
      end
    end
    startE = 1'b0;
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " busy_cycles"}, 32'(busy), 32'(exp_lat));
    chk({tag, " result"}, got, exp_res);
    chk({tag, " flagD"}, 32'(gd), 32'(exp_div));
    chk({tag, " flagM"}, 32'(gm), 32'(!exp_div));
    @(negedge clk); #1;
    chk({tag, " after_flags"}, {29'b0, flagM, flagD, mul_use}, 32'd0);
    chk({tag, " after_result"}, result_m, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          flag_cnt;
    int          busy_cnt;
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    int          sel;

    rst = 1'b1; startE = 1'b0; flushE = 1'b0; alu_opE = '0; SrcAE = '0; SrcBE = '0;
    #1;
    chk("reset outputs", {29'b0, flagM, flagD, mul_use}, 32'd0);
    chk("reset result", result_m, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed arithmetic cases.
    run_op("mul 7x6",        OP_MUL,    32'd7,          32'd6,          0);
    run_op("mulh min*min",   OP_MULH,   32'h8000_0000,  32'h8000_0000,  0);
    run_op("mulhu max*max",  OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  0);
    run_op("mulhsu -1*2",    OP_MULHSU, 32'hFFFF_FFFF,  32'd2,          0);
    run_op("div -7/2",       OP_DIV,    32'hFFFF_FFF9,  32'd2,          0);
    run_op("rem -7%2",       OP_REM,    32'hFFFF_FFF9,  32'd2,          0);
    run_op("divu 100/7",     OP_DIVU,   32'd100,        32'd7,          0);
    run_op("remu 100%7",     OP_REMU,   32'd100,        32'd7,          0);
    run_op("divu 5/0",       OP_DIVU,   32'd5,          32'd0,          0);
    run_op("remu 5%0",       OP_REMU,   32'd5,          32'd0,          0);
    run_op("div ovf",        OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  0);
    run_op("rem ovf",        OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  0);

    // Non-M opcode with startE: no stall, no result.
    @(negedge clk);
    startE = 1'b1; alu_opE = 5'b00000; SrcAE = 32'd1; SrcBE = 32'd1;
    #1;
    chk("non-m mul_use", 32'(mul_use), 32'd0);
    flag_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); startE = 1'b0; #1;
      flag_cnt += (flagM || flagD || mul_use) ? 1 : 0;
    end
    chk("non-m activity", 32'(flag_cnt), 32'd0);

    // Flush in IDLE suppresses accept.
    @(negedge clk);
    startE = 1'b1; flushE = 1'b1; alu_opE = OP_MUL; SrcAE = 32'd7; SrcBE = 32'd6;
    #1;
    chk("idle flush mul_use", 32'(mul_use), 32'd0);
    flag_cnt = 0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk); startE = 1'b0; flushE = 1'b0; #1;
      flag_cnt += (flagM || flagD || mul_use) ? 1 : 0;
    end
    chk("idle flush activity", 32'(flag_cnt), 32'd0);

    // startE re-presented at iteration 10 is ignored.
    run_op("mul ignore restart", OP_MUL, 32'd7, 32'd6, 10);

    // Flush at iteration 10 abandons the multiply.
    @(negedge clk);
    startE = 1'b1; alu_opE = OP_MUL; SrcAE = 32'd7; SrcBE = 32'd6;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk); startE = 1'b0;
    end
    @(negedge clk); flushE = 1'b1; #1;
    chk("flush cycle mul_use", 32'(mul_use), 32'd1);
    @(negedge clk); flushE = 1'b0; #1;
    chk("post-flush mul_use", 32'(mul_use), 32'd0);
    flag_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      flag_cnt += (flagM || flagD) ? 1 : 0;
      busy_cnt += mul_use ? 1 : 0;
    end
    chk("post-flush flags", 32'(flag_cnt), 32'd0);
    chk("post-flush busy", 32'(busy_cnt), 32'd0);

    // Asynchronous reset at iteration 20 of a divide.
    @(negedge clk);
    startE = 1'b1; alu_opE = OP_DIV; SrcAE = 32'd100; SrcBE = 32'd7;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk); startE = 1'b0;
    end
    #1;
    chk("pre-reset busy", 32'(mul_use), 32'd1);
    #1; rst = 1'b1; #1;
    chk("async reset outputs", {29'b0, flagM, flagD, mul_use}, 32'd0);
    chk("async reset result", result_m, 32'd0);
    @(negedge clk); rst = 1'b0;
    flag_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      flag_cnt += (flagM || flagD || mul_use) ? 1 : 0;
    end
    chk("post-reset activity", 32'(flag_cnt), 32'd0);
    run_op("div 9/3 after reset", OP_DIV, 32'd9, 32'd3, 0);

    // Randomized operations including special-case operands.
    for (int k = 0; k < 40; k++) begin
      rop = 5'(11 + $urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      else if (sel == 3) rb = 32'hFFFF_FFFF;
      run_op("random", rop, ra, rb, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
